spi_ram_master: RTL and testbench
=================================

// Module: spi_ram_master
// PURPOSE
//  SPI initiator for the SPI single-port RAM slave wrapper. It drives ss_n/MOSI and samples MISO.
//  It converts host commands ({cmd_type, cmd_data}) into 10-bit SPI frames, MSB first.
//  For read-data commands (2'b11) it also captures the 8-bit reply from MISO.
//  It sits between the host/test logic and the slave wrapper's serial pins, on the same sclk.
// PARAMETERS
//  RD_WAIT   2   sclk cycles between the last MOSI bit and the first MISO capture (read-data frames only)
//  GAP       1   minimum cycles ss_n stays high between frames (>=1)
// PORTS
//  sclk       in   1   clock; all logic on posedge
//  rst_n      in   1   asynchronous active-low reset
//  cmd_valid  in   1   host command valid
//  cmd_ready  out  1   block can accept a command
//  cmd_type   in   2   00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data
//  cmd_data   in   8   address/data byte (don't-care payload for 11, sent as-is)
//  rd_valid   out  1   one-cycle pulse: rd_data valid
//  rd_data    out  8   byte captured from MISO
//  busy       out  1   frame in progress (state != IDLE)
//  ss_n       out  1   slave select, active low
//  MOSI       out  1   serial data to slave
//  MISO       in   1   serial data from slave
// BEHAVIOUR
//  Reset values: ss_n=1, MOSI=0, cmd_ready=1, busy=0, rd_valid=0, rd_data=8'h00. FSM goes to IDLE.
//  FSM: IDLE -> SETUP -> SHIFT(10) -> HOLD -> [WAIT(RD_WAIT) -> CAPT(8)] -> GAP(GAP) -> IDLE.
//  IDLE:
//   - cmd_ready=1.
//   - When cmd_valid&&cmd_ready at a posedge: latch shreg={cmd_type,cmd_data}, ss_n<=0, go SETUP.
//  SETUP: 1 cycle with ss_n low and MOSI unchanged; gives the slave its CHK_CMD cycle.
//  SHIFT:
//   - 10 cycles; each posedge MOSI<=shreg[9], shreg<<=1.
//   - Bit order: cmd_type[1], cmd_type[0], cmd_data[7:0].
//  HOLD: 1 cycle; MOSI holds bit 0 so the slave samples it.
//   - cmd_type!=11: ss_n<=1 at the end of HOLD, MOSI<=0, go GAP. ss_n is low for exactly 12 cycles.
//   - cmd_type==11: ss_n stays low, go WAIT.
//  WAIT: RD_WAIT cycles; MOSI=0.
//  CAPT:
//   - 8 posedges; rx<={rx[6:0],MISO}, MSB first.
//   - After the 8th sample: rd_data<=rx, rd_valid=1 for 1 cycle, ss_n<=1, go GAP.
//   - ss_n is low for 12+RD_WAIT+8 cycles.
//  GAP:
//   - ss_n=1 for GAP cycles, then IDLE.
//   - cmd_ready is asserted again only in IDLE, so back-to-back frames are separated by >= GAP high cycles.
//  cmd_ready=0 in every state other than IDLE (base build); cmd inputs are ignored then.
//  rd_data holds its value until the next read-data capture.
//  Reset mid-frame: ss_n rises immediately (async), MOSI=0, no rd_valid, captured bits are discarded.
//  cmd_valid arriving in the same cycle as reset release is not accepted; acceptance starts at the first posedge with rst_n=1.
//  busy is registered and equals (state!=IDLE).
// CONFIGURATION
//  SPI_RAM_MASTER_CMDBUF_EN:
//   - Defined: adds a one-entry command buffer. cmd_ready=1 whenever the buffer is empty, including during a frame.
//   - A buffered command launches on the first IDLE cycle after GAP, going straight to SETUP with no extra idle cycle.
//   - Reset clears the buffer.
//  Undefined: no buffer; cmd_ready=1 only in IDLE.
// TESTING
//  T1: cmd 00/0x5A -> MOSI bits 0,0,0,1,0,1,1,0,1,0 on SHIFT cycles; ss_n low exactly 12 cycles; rd_valid never.
//  T2: cmd 11 with a MISO model returning 0xC3 after RD_WAIT -> rd_data=0xC3, rd_valid one cycle, ss_n low 22 cycles (RD_WAIT=2).
//  T3: cmd_valid held high with 3 queued cmds -> ss_n high >=GAP cycles between frames; cmd_ready low while busy (base build).
//  T4: rst_n asserted at SHIFT bit 5 -> ss_n=1, MOSI=0 same cycle; after release, cmd_ready=1 and no spurious rd_valid.
//  T5: with the wrapper: 00/0x10, 01/0xA5, 10/0x10, 11/0x00 -> rd_data=0xA5.
//  T6 (CMDBUF_EN): 2nd command offered mid-frame -> accepted immediately; its SETUP starts GAP cycles after the 1st frame's ss_n rise.

Source files
------------

// File: rtl/spi_ram_master.sv
// SPI initiator for the SPI single-port RAM slave: sends 10-bit {type,data} frames MSB first
// and captures the 8-bit reply of read-data frames. Define SPI_RAM_MASTER_CMDBUF_EN for a one-entry command buffer.
module spi_ram_master #(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       ss_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_WAIT, S_CAPT, S_GAP
  } state_t;

  localparam int CW = 16;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_shreg;
  logic          r_is_rd;
  logic [7:0]    r_rx;
  logic          r_ss_n;
  logic          r_mosi;
  logic          r_busy;
  logic          r_rd_valid;
  logic [7:0]    r_rd_data;

  logic          w_cnt_done;
  logic          w_cmd_ready;
  logic          w_launch;
  logic [9:0]    w_launch_frame;

`ifdef SPI_RAM_MASTER_CMDBUF_EN
  logic          r_buf_valid;
  logic [9:0]    r_buf;
`endif

  // r_cnt counts cycles spent in the current state; each timed state ends on its last count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_cnt_done = 1'b0;
    case (r_state)
      S_SHIFT: w_cnt_done = (r_cnt == CW'(9));
      S_WAIT:  w_cnt_done = (r_cnt == CW'(RD_WAIT - 1));
      S_CAPT:  w_cnt_done = (r_cnt == CW'(7));
      S_GAP:   w_cnt_done = (r_cnt == CW'(GAP - 1));
      default: w_cnt_done = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge sclk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next_state = S_SETUP;
      S_SETUP: w_next_state = S_SHIFT;
      S_SHIFT: if (w_cnt_done) w_next_state = S_HOLD;
      S_HOLD: begin
        if (!r_is_rd)          w_next_state = S_GAP;
        else if (RD_WAIT == 0) w_next_state = S_CAPT;
        else                   w_next_state = S_WAIT;
      end
      S_WAIT:  if (w_cnt_done) w_next_state = S_CAPT;
      S_CAPT:  if (w_cnt_done) w_next_state = S_GAP;
      S_GAP:   if (w_cnt_done) w_next_state = w_launch ? S_SETUP : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: handshake and frame launch
  always_comb begin
    w_launch_frame = {cmd_type, cmd_data};
`ifdef SPI_RAM_MASTER_CMDBUF_EN
    w_cmd_ready = !r_buf_valid;
    if (r_buf_valid) w_launch_frame = r_buf;
    if (r_state == S_IDLE)                  w_launch = r_buf_valid || cmd_valid;
    else if (r_state == S_GAP && w_cnt_done) w_launch = r_buf_valid;
    else                                    w_launch = 1'b0;
`else
    w_cmd_ready = (r_state == S_IDLE);
    w_launch    = (r_state == S_IDLE) && cmd_valid;
`endif
  end

`ifdef SPI_RAM_MASTER_CMDBUF_EN
  // Commands accepted outside IDLE wait here; in IDLE an empty buffer lets them launch directly.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
    end else if (cmd_valid && w_cmd_ready && r_state != S_IDLE) begin
      r_buf_valid <= 1'b1;
      r_buf       <= {cmd_type, cmd_data};
    end else if (w_launch && r_buf_valid) begin
      r_buf_valid <= 1'b0;
    end
  end
`endif

  // Serial datapath, counters and registered outputs
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_is_rd    <= 1'b0;
      r_rx       <= '0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_busy     <= (w_next_state != S_IDLE);
      r_ss_n     <= !(w_next_state inside {S_SETUP, S_SHIFT, S_HOLD, S_WAIT, S_CAPT});
      r_rd_valid <= 1'b0;
      r_cnt      <= (w_next_state != r_state || r_state == S_IDLE) ? '0 : r_cnt + CW'(1);

      if (w_launch) begin
        r_shreg <= w_launch_frame;
        r_is_rd <= &w_launch_frame[9:8];
      end else if (r_state == S_SHIFT) begin
        r_mosi  <= r_shreg[9];
        r_shreg <= {r_shreg[8:0], 1'b0};
      end

      if (r_state == S_HOLD) r_mosi <= 1'b0;

      if (r_state == S_CAPT) begin
        r_rx <= {r_rx[6:0], MISO};
        if (w_cnt_done) begin
          r_rd_data  <= {r_rx[6:0], MISO};
          r_rd_valid <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign busy      = r_busy;
  assign ss_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: vector table, hand-written corner sequences and
// random commands against a behavioural SPI RAM model.
module tb_spi_ram_master;

  localparam int RD_WAIT = 2;
  localparam int GAP     = 1;
  localparam int WR_LEN  = 12;
  localparam int RD_LEN  = 12 + RD_WAIT + 8;
  localparam int MB      = 12 + RD_WAIT;   // frame cycle whose end-edge samples MISO bit 7

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       ss_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] t;
    logic [7:0] d;
    logic [7:0] miso;
    int         low;
    logic [7:0] rd;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] mem[256];
  logic [7:0] wa, ra, model_rd;

  spi_ram_master #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .sclk(sclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 sclk = ~sclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge sclk);
    while (!(cmd_ready && !busy && ss_n) && n < 100) begin
      @(negedge sclk);
      n++;
    end
    check({tag, ".idle"}, 32'(n < 100), 1);
  endtask

  // One complete frame; bench cycle k is the cycle after the k-th posedge following acceptance.
  task automatic do_frame(input logic [1:0] t, input logic [7:0] d, input logic [7:0] miso_b,
                          input int exp_low, input logic [7:0] exp_rd, input string tag);
    logic [9:0] word = '0;
    int  idx = 0, low = 0, rdv_cnt = 0, rdv_pos = -1;
    bit  done = 0;
    bit  is_rd = (t == 2'b11);
    wait_idle(tag);
    cmd_valid = 1'b1; cmd_type = t; cmd_data = d;
    @(posedge sclk);
    while (!done && idx < 60) begin
      @(negedge sclk);
      if (idx == 0) begin
        cmd_valid = 1'b0;
        check({tag, ".busy0"}, 32'(busy), 1);
`ifndef SPI_RAM_MASTER_CMDBUF_EN
        check({tag, ".ready0"}, 32'(cmd_ready), 0);
`endif
      end
      if (!ss_n) begin
        low++;
        if (idx >= 2 && idx <= 11) word = {word[8:0], MOSI};
      end else begin
        done = 1;
      end
      if (rd_valid) begin rdv_cnt++; rdv_pos = idx; end
      if (idx >= MB && idx < MB + 8) MISO = miso_b[7 - (idx - MB)];
      else                           MISO = 1'($urandom);
      idx++;
    end
    check({tag, ".mosi_bits"}, 32'(word), 32'({t, d}));
    check({tag, ".ss_low"}, 32'(low), 32'(exp_low));
    check({tag, ".mosi_end"}, 32'(MOSI), 0);
    @(negedge sclk);
    if (rd_valid) begin rdv_cnt++; rdv_pos = idx; end
    check({tag, ".rdv_cnt"}, 32'(rdv_cnt), is_rd ? 1 : 0);
    check({tag, ".rdv_pos"}, 32'(rdv_pos), is_rd ? 32'(exp_low) : 32'hFFFF_FFFF);
    check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
    check({tag, ".busy_end"}, 32'(busy), 0);
  endtask

  // SPI RAM slave model: address/data writes update it; read-data returns mem[read address].
  task automatic model_cmd(input logic [1:0] t, input logic [7:0] d, input string tag);
    logic [7:0] miso_b = 8'($urandom);
    case (t)
      2'b00: wa = d;
      2'b01: mem[wa] = d;
      2'b10: ra = d;
      default: begin miso_b = mem[ra]; model_rd = mem[ra]; end
    endcase
    do_frame(t, d, miso_b, (t == 2'b11) ? RD_LEN : WR_LEN, model_rd, tag);
  endtask

  task automatic t3_queue();
    logic [1:0] qt[3] = '{2'b01, 2'b11, 2'b00};
    logic [7:0] qd[3] = '{8'h33, 8'h00, 8'h44};
    int  qi = 0, frames = 0, high = 0, steps = 0, ready_bad = 0;
    int  min_gap = 1000, max_gap = 0;
    bit  acc = 0, prev_ss = 1;
`ifdef SPI_RAM_MASTER_CMDBUF_EN
    int  exp_gap = GAP;
`else
    int  exp_gap = GAP + 1;
`endif
    wait_idle("t3");
    while (steps < 300 && !(qi == 3 && ss_n && !busy)) begin
      if (steps > 0) @(negedge sclk);
      steps++;
      if (acc) qi++;
      if (qi < 3) begin cmd_valid = 1'b1; cmd_type = qt[qi]; cmd_data = qd[qi]; end
      else          cmd_valid = 1'b0;
      acc = cmd_valid && cmd_ready;
      if (ss_n) high++;
      else begin
        if (prev_ss && frames > 0) begin
          if (high < min_gap) min_gap = high;
          if (high > max_gap) max_gap = high;
        end
        if (prev_ss) frames++;
        high = 0;
      end
      prev_ss = ss_n;
      if (cmd_ready === busy) ready_bad++;
    end
    cmd_valid = 1'b0;
    check("t3.timeout", 32'(steps < 300), 1);
    check("t3.frames", 32'(frames), 3);
    check("t3.gap_min", 32'(min_gap), 32'(exp_gap));
    check("t3.gap_max", 32'(max_gap), 32'(exp_gap));
`ifndef SPI_RAM_MASTER_CMDBUF_EN
    check("t3.ready_vs_busy", 32'(ready_bad), 0);
`endif
  endtask

  task automatic t4_reset_mid_frame();
    int rdv = 0, low = 0;
    wait_idle("t4");
    cmd_valid = 1'b1; cmd_type = 2'b11; cmd_data = 8'hFF;
    @(posedge sclk);
    for (int k = 0; k < 8; k++) begin
      @(negedge sclk);
      if (k == 0) cmd_valid = 1'b0;
    end
    check("t4.in_frame_ss", 32'(ss_n), 0);
    check("t4.in_frame_mosi", 32'(MOSI), 1);
    rst_n = 1'b0;
    #1;
    check("t4.rst_ss", 32'(ss_n), 1);
    check("t4.rst_mosi", 32'(MOSI), 0);
    check("t4.rst_busy", 32'(busy), 0);
    check("t4.rst_ready", 32'(cmd_ready), 1);
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;
    model_rd = 8'h00;
    for (int k = 0; k < 25; k++) begin
      @(negedge sclk);
      MISO = 1'($urandom);
      if (rd_valid) rdv++;
      if (!ss_n) low++;
    end
    check("t4.no_rdv", 32'(rdv), 0);
    check("t4.no_frame", 32'(low), 0);
    check("t4.ready", 32'(cmd_ready), 1);
    check("t4.rd_data", 32'(rd_data), 0);
  endtask

`ifdef SPI_RAM_MASTER_CMDBUF_EN
  task automatic t6_buffered();
    int  hi = 0, idx = 0;
    bit  rose = 0, fell2 = 0;
    wait_idle("t6");
    cmd_valid = 1'b1; cmd_type = 2'b00; cmd_data = 8'h11;
    @(posedge sclk);
    while (!fell2 && idx < 60) begin
      @(negedge sclk);
      if (idx == 0) cmd_valid = 1'b0;
      if (idx == 5) begin
        check("t6.ready_mid", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_type = 2'b01; cmd_data = 8'h22;
      end
      if (idx == 6) begin
        cmd_valid = 1'b0;
        check("t6.ready_full", 32'(cmd_ready), 0);
      end
      if (ss_n) begin rose = 1; hi++; end
      else if (rose) fell2 = 1;
      idx++;
    end
    check("t6.second_frame", 32'(fell2), 1);
    check("t6.gap", 32'(hi), 32'(GAP));
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    wa = 8'h00; ra = 8'h00; model_rd = 8'h00;

    tbl[0] = '{2'b00, 8'h5A, 8'h00, WR_LEN, 8'h00};
    tbl[1] = '{2'b11, 8'h00, 8'hC3, RD_LEN, 8'hC3};
    tbl[2] = '{2'b01, 8'hA5, 8'hFF, WR_LEN, 8'hC3};
    tbl[3] = '{2'b10, 8'h10, 8'h00, WR_LEN, 8'hC3};
    tbl[4] = '{2'b11, 8'hFF, 8'h3C, RD_LEN, 8'h3C};
    tbl[5] = '{2'b11, 8'h55, 8'h00, RD_LEN, 8'h00};
    tbl[6] = '{2'b11, 8'h81, 8'h81, RD_LEN, 8'h81};
    tbl[7] = '{2'b00, 8'hFF, 8'h7E, WR_LEN, 8'h81};

    // Reset values, with a command already offered while reset is held
    cmd_valid = 1'b1; cmd_type = 2'b00; cmd_data = 8'h99;
    repeat (3) @(negedge sclk);
    check("rst.ss_n", 32'(ss_n), 1);
    check("rst.mosi", 32'(MOSI), 0);
    check("rst.ready", 32'(cmd_ready), 1);
    check("rst.busy", 32'(busy), 0);
    check("rst.rd_valid", 32'(rd_valid), 0);
    check("rst.rd_data", 32'(rd_data), 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) do_frame(tbl[i].t, tbl[i].d, tbl[i].miso, tbl[i].low, tbl[i].rd,
                              $sformatf("vec%0d", i));

    t3_queue();
    t4_reset_mid_frame();

    model_cmd(2'b00, 8'h10, "t5.wa");
    model_cmd(2'b01, 8'hA5, "t5.wd");
    model_cmd(2'b10, 8'h10, "t5.ra");
    model_cmd(2'b11, 8'h00, "t5.rd");
    check("t5.readback", 32'(rd_data), 32'h0000_00A5);

    for (int n = 0; n < 40; n++)
      model_cmd(2'($urandom_range(0, 3)), 8'($urandom), $sformatf("rnd%0d", n));

`ifdef SPI_RAM_MASTER_CMDBUF_EN
    t6_buffered();
`endif

    repeat (3) @(negedge sclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
